// File: rtl/game_controller.sv
// Bomb sequencer: arms the countdown, serializes mistake pulses into strikes, declares win/loss.
// Optional STRIKE_SPEEDUP_EN makes the timer speed track the strike count.
module game_controller #(
  parameter int NUM_MODULES = 4,
  parameter int MAX_STRIKES = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [NUM_MODULES-1:0] mistake_i,
  input  logic [NUM_MODULES-1:0] solved_i,
  input  logic                   timer_expired_i,
  output logic                   timer_load_o,
  output logic                   timer_run_o,
  output logic [1:0]             strikes_o,
  output logic                   strike_pulse_o,
  output logic [1:0]             speed_o,
  output logic                   explode_strike_o,
  output logic                   explode_timer_o,
  output logic                   game_won_o,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_WON   = 2'd2,
    S_LOST  = 2'd3
  } state_t;

  localparam logic [1:0] MAX_STRIKES_L = 2'(MAX_STRIKES);

  state_t                 state_q, state_d;
  logic [1:0]             strikes_q, strikes_d;
  logic [NUM_MODULES-1:0] pending_q, pending_d;
  logic                   timer_load_q, timer_load_d;
  logic                   timer_run_q, timer_run_d;
  logic                   strike_pulse_q, strike_pulse_d;
  logic                   explode_strike_q, explode_strike_d;
  logic                   explode_timer_q, explode_timer_d;
  logic                   game_won_q, game_won_d;

  logic [NUM_MODULES-1:0] live_mistake;
  logic [NUM_MODULES-1:0] req;
  logic [NUM_MODULES-1:0] grant;

  // Mistakes from already-solved modules never count.
  generate
    for (genvar gi = 0; gi < NUM_MODULES; gi++) begin : g_mask
      assign live_mistake[gi] = mistake_i[gi] & ~solved_i[gi];
    end
  endgenerate

  assign req   = pending_q | live_mistake;
  assign grant = req & (~req + NUM_MODULES'(1));

  always_comb begin
    state_d          = state_q;
    strikes_d        = strikes_q;
    pending_d        = pending_q;
    timer_load_d     = 1'b0;
    timer_run_d      = timer_run_q;
    strike_pulse_d   = 1'b0;
    explode_strike_d = explode_strike_q;
    explode_timer_d  = explode_timer_q;
    game_won_d       = game_won_q;

    case (state_q)
      S_IDLE: begin
        strikes_d   = 2'd0;
        pending_d   = '0;
        timer_run_d = 1'b0;
        if (start_i) begin
          state_d      = S_ARMED;
          timer_load_d = 1'b1;
          timer_run_d  = 1'b1;
        end
      end
      S_ARMED: begin
        timer_run_d = 1'b1;
        if (req != '0) begin
          strike_pulse_d = 1'b1;
          pending_d      = req & ~grant;
          if (strikes_q != MAX_STRIKES_L) strikes_d = strikes_q + 2'd1;
        end
        // Loss by timer outranks loss by strikes, which outranks a win.
        if (timer_expired_i) begin
          state_d         = S_LOST;
          explode_timer_d = 1'b1;
          pending_d       = '0;
          timer_run_d     = 1'b0;
        end else if ((req != '0) && (strikes_d == MAX_STRIKES_L)) begin
          state_d          = S_LOST;
          explode_strike_d = 1'b1;
          pending_d        = '0;
          timer_run_d      = 1'b0;
        end else if (&solved_i) begin
          state_d     = S_WON;
          game_won_d  = 1'b1;
          pending_d   = '0;
          timer_run_d = 1'b0;
        end
      end
      default: begin
        if (start_i) begin
          state_d          = S_IDLE;
          strikes_d        = 2'd0;
          pending_d        = '0;
          timer_run_d      = 1'b0;
          explode_strike_d = 1'b0;
          explode_timer_d  = 1'b0;
          game_won_d       = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q          <= S_IDLE;
      strikes_q        <= 2'd0;
      pending_q        <= '0;
      timer_load_q     <= 1'b0;
      timer_run_q      <= 1'b0;
      strike_pulse_q   <= 1'b0;
      explode_strike_q <= 1'b0;
      explode_timer_q  <= 1'b0;
      game_won_q       <= 1'b0;
    end else begin
      state_q          <= state_d;
      strikes_q        <= strikes_d;
      pending_q        <= pending_d;
      timer_load_q     <= timer_load_d;
      timer_run_q      <= timer_run_d;
      strike_pulse_q   <= strike_pulse_d;
      explode_strike_q <= explode_strike_d;
      explode_timer_q  <= explode_timer_d;
      game_won_q       <= game_won_d;
    end
  end

`ifdef STRIKE_SPEEDUP_EN
  logic [1:0] speed_q;

  always_ff @(posedge clock_i) begin
    if (!reset_i) speed_q <= 2'd0;
    else          speed_q <= strikes_d;
  end

  assign speed_o = speed_q;
`else
  assign speed_o = 2'd0;
`endif

  assign state_o          = state_q;
  assign strikes_o        = strikes_q;
  assign timer_load_o     = timer_load_q;
  assign timer_run_o      = timer_run_q;
  assign strike_pulse_o   = strike_pulse_q;
  assign explode_strike_o = explode_strike_q;
  assign explode_timer_o  = explode_timer_q;
  assign game_won_o       = game_won_q;

endmodule

// File: tb/tb_game_controller.sv
// Table-driven bench for game_controller: per-cycle stimulus records with expected outputs
// queued as a scoreboard, plus a hand-written simultaneous-mistake sequence.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       rst_n, start, texp;
  logic [3:0] mistake, solved;
  logic       timer_load, timer_run, strike_pulse, explode_strike, explode_timer, game_won;
  logic [1:0] strikes, speed, state;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  game_controller #(.NUM_MODULES(4), .MAX_STRIKES(3)) dut (
    .clock_i          (clk),
    .reset_i          (rst_n),
    .start_i          (start),
    .mistake_i        (mistake),
    .solved_i         (solved),
    .timer_expired_i  (texp),
    .timer_load_o     (timer_load),
    .timer_run_o      (timer_run),
    .strikes_o        (strikes),
    .strike_pulse_o   (strike_pulse),
    .speed_o          (speed),
    .explode_strike_o (explode_strike),
    .explode_timer_o  (explode_timer),
    .game_won_o       (game_won),
    .state_o          (state)
  );

  typedef struct {
    string      name;
    logic       rst_n;
    logic       start;
    logic [3:0] mistake;
    logic [3:0] solved;
    logic       texp;
    logic [1:0] st;
    logic [1:0] stk;
    logic       pulse;
    logic       load;
    logic       run;
    logic       xs;
    logic       xt;
    logic       won;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  task automatic add(input string name, input logic r, input logic s, input logic [3:0] m,
                     input logic [3:0] sv, input logic te, input logic [1:0] st,
                     input logic [1:0] stk, input logic p, input logic ld, input logic rn,
                     input logic xs, input logic xt, input logic wn);
    vec_t v;
    v.name = name; v.rst_n = r; v.start = s; v.mistake = m; v.solved = sv; v.texp = te;
    v.st = st; v.stk = stk; v.pulse = p; v.load = ld; v.run = rn;
    v.xs = xs; v.xt = xt; v.won = wn;
    vecs.push_back(v);
  endtask

  function automatic logic [1:0] exp_speed(input logic [1:0] stk);
`ifdef STRIKE_SPEEDUP_EN
    return stk;
`else
    return 2'd0;
`endif
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got st/stk/pulse/load/run/xs/xt/won/speed=%b required %b", name, got, want);
    end else begin
      $display("[TB] ok %s: %b", name, got);
    end
  endtask

  initial begin
    vec_t e;
    int   cycles, pulses, prev;
    logic step_ok;

    rst_n = 1'b0; start = 1'b0; mistake = '0; solved = '0; texp = 1'b0;

    //   name            rst st mistake  solved  te  state stk pl ld rn xs xt wn
    add("reset_start",   0, 1, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    add("idle",          1, 0, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    add("arm",           1, 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 1, 1, 0, 0, 0);
    add("armed_quiet",   1, 0, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0, 1, 0, 0, 0);
    add("mis0101_a",     1, 0, 4'b0101, 4'b0000, 0, 2'd1, 1, 1, 0, 1, 0, 0, 0);
    add("mis0101_b",     1, 0, 4'b0000, 4'b0000, 0, 2'd1, 2, 1, 0, 1, 0, 0, 0);
    add("mis0101_done",  1, 0, 4'b0000, 4'b0000, 0, 2'd1, 2, 0, 0, 1, 0, 0, 0);
    add("third_strike",  1, 0, 4'b1000, 4'b0000, 0, 2'd3, 3, 1, 0, 0, 1, 0, 0);
    add("lost_frozen",   1, 0, 4'b1111, 4'b0000, 0, 2'd3, 3, 0, 0, 0, 1, 0, 0);
    add("lost_to_idle",  1, 1, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    add("rearm_1",       1, 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 1, 1, 0, 0, 0);
    add("timer_vs_win",  1, 0, 4'b0000, 4'b1111, 1, 2'd3, 0, 0, 0, 0, 0, 1, 0);
    add("lost_to_idle2", 1, 1, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    add("rearm_2",       1, 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 1, 1, 0, 0, 0);
    add("solved_mis",    1, 0, 4'b0010, 4'b0010, 0, 2'd1, 0, 0, 0, 1, 0, 0, 0);
    add("win",           1, 0, 4'b0000, 4'b1111, 0, 2'd2, 0, 0, 0, 0, 0, 0, 1);
    add("won_frozen",    1, 0, 4'b0001, 4'b1111, 0, 2'd2, 0, 0, 0, 0, 0, 0, 1);
    add("won_to_idle",   1, 1, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    add("rearm_3",       1, 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 1, 1, 0, 0, 0);
    add("mis0110",       1, 0, 4'b0110, 4'b0000, 0, 2'd1, 1, 1, 0, 1, 0, 0, 0);
    add("merge_pend2",   1, 0, 4'b0100, 4'b0000, 0, 2'd1, 2, 1, 0, 1, 0, 0, 0);
    add("merged_none",   1, 0, 4'b0000, 4'b0000, 0, 2'd1, 2, 0, 0, 1, 0, 0, 0);
    add("start_ignored", 1, 1, 4'b0000, 4'b0000, 0, 2'd1, 2, 0, 0, 1, 0, 0, 0);
    add("mid_reset",     0, 1, 4'b0001, 4'b0000, 0, 2'd0, 0, 0, 0, 0, 0, 0, 0);
    add("rearm_4",       1, 1, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 1, 1, 0, 0, 0);
    add("mis0011",       1, 0, 4'b0011, 4'b0000, 0, 2'd1, 1, 1, 0, 1, 0, 0, 0);
    add("b2b_mis0_a",    1, 0, 4'b0001, 4'b0000, 0, 2'd1, 2, 1, 0, 1, 0, 0, 0);
    add("b2b_mis0_b",    1, 0, 4'b0001, 4'b0000, 0, 2'd3, 3, 1, 0, 0, 1, 0, 0);
    add("b2b_after",     1, 0, 4'b0000, 4'b0000, 0, 2'd3, 3, 0, 0, 0, 1, 0, 0);

    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n; start = vecs[i].start; mistake = vecs[i].mistake;
      solved = vecs[i].solved; texp = vecs[i].texp;
      exp_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check(e.name,
            {state, strikes, strike_pulse, timer_load, timer_run, explode_strike,
             explode_timer, game_won, speed},
            {e.st, e.stk, e.pulse, e.load, e.run, e.xs, e.xt, e.won, exp_speed(e.stk)});
    end

    // Four simultaneous mistakes: one strike per edge, loss on the third edge.
    rst_n = 1'b1; start = 1'b1; mistake = '0; solved = '0; texp = 1'b0;
    @(posedge clk); #1;   // LOST -> IDLE
    @(posedge clk); #1;   // IDLE -> ARMED
    start = 1'b0;
    mistake = 4'b1111;
    prev = 0; cycles = 0; pulses = 0; step_ok = 1'b1;
    do begin
      @(posedge clk); #1;
      mistake = '0;
      cycles++;
      if (strike_pulse) pulses++;
      if (int'(strikes) - prev > 1) step_ok = 1'b0;
      prev = int'(strikes);
    end while (state != 2'd3 && cycles < 10);
    check("sim4_cycles", 14'(cycles), 14'd3);
    check("sim4_pulses", 14'(pulses), 14'd3);
    check("sim4_step", {13'd0, step_ok}, 14'd1);
    check("sim4_final", {state, strikes, explode_strike, explode_timer, timer_run, 7'd0},
          {2'd3, 2'd3, 1'b1, 1'b0, 1'b0, 7'd0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_controller.md
# game_controller

Top-level bomb sequencer for the game. It arms the countdown timer on start and collects mistake pulses from the puzzle modules, serializing simultaneous mistakes into one strike per cycle. It tracks per-module solved flags and declares the round won or lost. It feeds the timer's run/load controls and supplies the loss sources that drive the game-over flag.

## Interface
- NUM_MODULES, 4: number of puzzle modules (1..8)
- MAX_STRIKES, 3: strike count that ends the game (1..3)
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-low; 0 on a rising edge resets every register
- start  in  1  one-cycle start/restart request
- mistake  in  NUM_MODULES  per-module one-cycle mistake pulses
- solved  in  NUM_MODULES  per-module solved levels; held high once solved
- timer_expired  in  1  countdown reached zero
- timer_load  out  1  one-cycle pulse to reload the countdown
- timer_run  out  1  countdown enable
- strikes  out  2  current strike count
- strike_pulse  out  1  one-cycle pulse per strike taken
- speed  out  2  timer rate select, 0 = normal
- explode_strike  out  1  level: game ended by strikes
- explode_timer  out  1  level: game ended by timer
- game_won  out  1  level: all modules solved
- state  out  2  IDLE=0, ARMED=1, WON=2, LOST=3

## Operation
- All outputs are registered. Reset values: state=IDLE; strikes=0; speed=0; pending=0; all 1-bit outputs 0.
- IDLE: strikes and pending are held at 0. start=1 moves to ARMED and pulses timer_load for that one cycle.
- ARMED:
  - timer_run=1.
  - Request vector: req = pending | (mistake & ~solved). Mistakes from solved modules are discarded.
  - Arbitration: fixed priority, lowest index first.
  - Each cycle with req≠0: grant the lowest set bit, strikes+1, strike_pulse=1, pending ← req & ~grant.
  - A module pulsing again while its bit is still pending is merged into that one pending strike.
- ARMED exit checks, all evaluated on the same edge, in priority order:
  1. timer_expired=1 → LOST with explode_timer=1.
  2. The increment makes strikes == MAX_STRIKES → LOST with explode_strike=1.
  3. solved is all ones and neither loss condition holds → WON with game_won=1.
- Any transition out of ARMED clears pending and drops timer_run.
- WON/LOST:
  - Terminal. strikes is frozen and further mistakes are ignored.
  - start=1 returns to IDLE, clearing strikes, speed and the explode/won flags.
  - start does not re-arm directly; a second start is required.
- start while in ARMED is ignored.
- reset low overrides everything, including a start in the same cycle.
- strikes saturates at MAX_STRIKES and never wraps.

## Timing
- start sampled at edge k: state=ARMED and timer_load=1 during cycle k..k+1. timer_run=1 from the same cycle; timer_load=0 after.
- mistake sampled at edge k: strikes and strike_pulse update after edge k, so latency is 1 cycle.
- N simultaneous mistakes produce N strike pulses on consecutive cycles.
  - Example with MAX_STRIKES=3 and 3 simultaneous mistakes: loss on the third edge.
- Loss or win flags assert 1 cycle after the deciding edge inputs, in the same cycle that state changes.
- timer_expired and the final solved bit arriving on the same edge: LOST wins.

## Configuration
- STRIKE_SPEEDUP_EN defined:
  - speed = strikes (0..3), registered with strikes.
  - speed returns to 0 on the IDLE transition.
- Undefined: speed is tied to 0 and no speed logic is generated.

## Test plan
- Reset with start=1 and reset=0 on the same edge → state=IDLE, all outputs 0. Release reset, pulse start → timer_load=1 for exactly one cycle, timer_run=1, state=ARMED.
- ARMED, mistake=4'b0101 for one cycle → strike_pulse high two consecutive cycles, strikes 1 then 2. With STRIKE_SPEEDUP_EN, speed tracks 1, 2; without, speed=0.
- ARMED with strikes=2, mistake[3] pulse → strikes=3, state=LOST, explode_strike=1, timer_run=0. Further mistakes leave strikes=3.
- ARMED, solved=4'b1111 and timer_expired=1 on the same edge → LOST with explode_timer=1, game_won=0.
- ARMED, solved=4'b0010 and mistake=4'b0010 → no strike. solved rises to 4'b1111 → WON, game_won=1. First start → IDLE with strikes=0; second start → ARMED.
- mistake[0] pulsed on two back-to-back cycles while mistake[1] is pending → strikes increments by at most one per cycle, and total strikes equals the distinct pending grants.
